// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction-fetch stage. Owns the PC, addresses a combinational
//            instruction ROM and registers the fetched word into IF/ID.
//            Optional macro FETCH_PERF_CNT_EN adds fetch/stall counters.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] HALT_WORD = 16'hFFFF,
    parameter logic [15:0] NOP_WORD  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus1,
    output logic        if_valid,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] fetch_count,
    output logic [15:0] stall_count
`endif
);

    localparam logic [1:0] c_boot   = 2'd0;
    localparam logic [1:0] c_run    = 2'd1;
    localparam logic [1:0] c_halted = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [15:0] r_pc;
    logic [15:0] r_if_instr;
    logic [15:0] r_if_pc;
    logic [15:0] r_if_pc_plus1;
    logic        r_if_valid;

    logic        w_load_target;
    logic        w_capture;
    logic        w_squash;
    logic        w_pc_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_boot;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_boot: w_state_next = c_run;
            c_run: begin
                if (!redirect_valid && !flush && !stall && (imem_data == HALT_WORD)) begin
                    w_state_next = c_halted;
                end
            end
            c_halted: begin
                if (redirect_valid) begin
                    w_state_next = c_run;
                end
            end
            default: w_state_next = c_boot;
        endcase
    end

    // Redirect outranks flush, flush outranks stall; in HALTED any unstalled
    // edge retires the halt word from IF/ID.
    always_comb begin
        w_load_target = 1'b0;
        w_capture     = 1'b0;
        w_squash      = 1'b0;
        w_pc_inc      = 1'b0;
        case (r_state)
            c_boot: begin
                w_load_target = redirect_valid;
            end
            c_run: begin
                w_load_target = redirect_valid;
                w_capture     = !redirect_valid && !flush && !stall;
                w_squash      = redirect_valid || flush;
                w_pc_inc      = !redirect_valid && !flush && !stall && (imem_data != HALT_WORD);
            end
            c_halted: begin
                w_load_target = redirect_valid;
                w_squash      = redirect_valid || flush || !stall;
            end
            default: begin
                w_load_target = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_if_instr    <= NOP_WORD;
            r_if_pc       <= 16'h0000;
            r_if_pc_plus1 <= 16'h0000;
            r_if_valid    <= 1'b0;
        end else begin
            if (w_load_target) begin
                r_pc <= redirect_target;
            end else if (w_pc_inc) begin
                r_pc <= r_pc + 16'd1;
            end

            if (w_capture) begin
                r_if_instr    <= imem_data;
                r_if_pc       <= r_pc;
                r_if_pc_plus1 <= r_pc + 16'd1;
                r_if_valid    <= 1'b1;
            end else if (w_squash) begin
                r_if_instr    <= NOP_WORD;
                r_if_valid    <= 1'b0;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_pc_plus1 = r_if_pc_plus1;
    assign if_valid    = r_if_valid;
    assign halted      = (r_state == c_halted);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_count;
    logic [15:0] r_stall_count;
    logic        w_stall_evt;

    assign w_stall_evt = (r_state == c_run) && stall && !flush && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_count <= 16'h0000;
            r_stall_count <= 16'h0000;
        end else begin
            if (w_capture && (r_fetch_count != 16'hFFFF)) begin
                r_fetch_count <= r_fetch_count + 16'd1;
            end
            if (w_stall_evt && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit against a spec-level model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam logic [15:0] HALT = 16'hFFFF;
    localparam logic [15:0] NOP  = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_target = 16'h0000;
    logic [15:0] imem_addr, imem_data, if_instr, if_pc, if_pc_plus1;
    logic        if_valid, halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count, stall_count;
`endif

    logic [15:0] rom [0:65535];
    logic [15:0] prog [0:5] = '{16'h8040, 16'h8081, 16'h0280, 16'h0285, 16'hA005, 16'hA007};

    int checks = 0;
    int failures = 0;

    // Reference model: phase 0=BOOT, 1=RUN, 2=HALTED
    int          m_phase;
    logic [15:0] m_pc, m_instr, m_ipc, m_ipc1;
    logic        m_valid;
    logic [15:0] m_fetch, m_stallc;

    logic [65:0] act;

    assign imem_data = rom[imem_addr];
    assign act = {imem_addr, if_instr, if_pc, if_pc_plus1, if_valid, halted};

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus1(if_pc_plus1),
        .if_valid(if_valid), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    function automatic logic [65:0] exp_vec();
        return {m_pc, m_instr, m_ipc, m_ipc1, m_valid, (m_phase == 2)};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pc = 16'h0000; m_instr = NOP; m_ipc = 16'h0000;
        m_ipc1 = 16'h0000; m_valid = 1'b0; m_fetch = 16'h0000; m_stallc = 16'h0000;
    endtask

    task automatic model_edge();
        logic [15:0] word;
        if (m_phase == 0) begin
            if (redirect_valid) m_pc = redirect_target;
            m_phase = 1;
        end else if (redirect_valid) begin
            m_pc = redirect_target; m_valid = 1'b0; m_instr = NOP; m_phase = 1;
        end else if (flush) begin
            m_valid = 1'b0; m_instr = NOP;
        end else if (stall) begin
            if (m_phase == 1 && m_stallc != 16'hFFFF) m_stallc = m_stallc + 16'd1;
        end else if (m_phase == 2) begin
            m_valid = 1'b0; m_instr = NOP;
        end else begin
            word = rom[m_pc];
            m_instr = word; m_ipc = m_pc; m_ipc1 = m_pc + 16'd1; m_valid = 1'b1;
            if (m_fetch != 16'hFFFF) m_fetch = m_fetch + 16'd1;
            if (word == HALT) m_phase = 2;
            else m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic s, input logic f, input logic r, input logic [15:0] t);
        stall = s; flush = f; redirect_valid = r; redirect_target = t;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0, 16'h0000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic run_plain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        set_in(1'b1, 1'b1, 1'b1, 16'h1234);
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (act !== exp_vec()) begin
            failures++; $display("FAIL reset_hold act=%h exp=%h", act, exp_vec());
        end
        checks++;
        if ({imem_addr, if_valid, halted} !== {16'h0000, 1'b0, 1'b0}) begin
            failures++; $display("FAIL reset_const addr=%h valid=%b halted=%b", imem_addr, if_valid, halted);
        end
        do_reset();
    endtask

    task automatic test_sequence();
        do_reset();
        tick();
        checks++;
        if (if_valid !== 1'b0 || act !== exp_vec()) begin
            failures++; $display("FAIL boot_edge act=%h exp=%h", act, exp_vec());
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (act !== exp_vec() ||
                {if_instr, if_pc, if_pc_plus1, if_valid} !== {prog[i], 16'(i), 16'(i + 1), 1'b1}) begin
                failures++;
                $display("FAIL seq_%0d act=%h exp=%h instr=%h", i, act, exp_vec(), if_instr);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        run_plain(4);
        set_in(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (act !== exp_vec() || {if_instr, if_pc, imem_addr} !== {16'h0280, 16'h0002, 16'h0003}) begin
                failures++; $display("FAIL stall_hold_%0d act=%h exp=%h", i, act, exp_vec());
            end
        end
        set_in(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checks++;
        if (act !== exp_vec() || {if_instr, if_pc} !== {16'h0285, 16'h0003}) begin
            failures++; $display("FAIL stall_release act=%h exp=%h", act, exp_vec());
        end
    endtask

    task automatic test_redirect();
        do_reset();
        run_plain(5);
        set_in(1'b1, 1'b1, 1'b1, 16'h0010);
        tick();
        checks++;
        if (act !== exp_vec() || {imem_addr, if_valid, if_instr} !== {16'h0010, 1'b0, 16'h0000}) begin
            failures++; $display("FAIL redirect_edge act=%h exp=%h", act, exp_vec());
        end
        set_in(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checks++;
        if (act !== exp_vec() || {if_instr, if_pc, if_valid} !== {rom[16], 16'h0010, 1'b1}) begin
            failures++; $display("FAIL redirect_capture act=%h exp=%h", act, exp_vec());
        end
    endtask

    task automatic test_flush();
        do_reset();
        run_plain(3);
        set_in(1'b1, 1'b1, 1'b0, 16'h0000);
        tick();
        checks++;
        if (act !== exp_vec() || {if_valid, imem_addr} !== {1'b0, 16'h0002}) begin
            failures++; $display("FAIL flush_edge act=%h exp=%h", act, exp_vec());
        end
        set_in(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checks++;
        if (act !== exp_vec() || {if_instr, if_pc} !== {16'h0280, 16'h0002}) begin
            failures++; $display("FAIL flush_refetch act=%h exp=%h", act, exp_vec());
        end
    endtask

    task automatic test_halt();
        do_reset();
        run_plain(8);
        checks++;
        if (act !== exp_vec() || {if_instr, if_valid, halted, imem_addr} !== {HALT, 1'b1, 1'b1, 16'h0006}) begin
            failures++; $display("FAIL halt_edge act=%h exp=%h", act, exp_vec());
        end
        set_in(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        checks++;
        if (act !== exp_vec() || {if_instr, if_valid} !== {HALT, 1'b1}) begin
            failures++; $display("FAIL halt_stall act=%h exp=%h", act, exp_vec());
        end
        set_in(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checks++;
        if (act !== exp_vec() || {if_valid, imem_addr, halted} !== {1'b0, 16'h0006, 1'b1}) begin
            failures++; $display("FAIL halt_retire act=%h exp=%h", act, exp_vec());
        end
        set_in(1'b0, 1'b1, 1'b0, 16'h0000);
        tick();
        checks++;
        if (act !== exp_vec() || halted !== 1'b1) begin
            failures++; $display("FAIL halt_flush act=%h exp=%h", act, exp_vec());
        end
        set_in(1'b0, 1'b0, 1'b1, 16'h0000);
        tick();
        checks++;
        if (act !== exp_vec() || {halted, if_valid, imem_addr} !== {1'b0, 1'b0, 16'h0000}) begin
            failures++; $display("FAIL halt_redirect act=%h exp=%h", act, exp_vec());
        end
        set_in(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checks++;
        if (act !== exp_vec() || {if_instr, if_valid} !== {16'h8040, 1'b1}) begin
            failures++; $display("FAIL halt_resume act=%h exp=%h", act, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        // redirect on the edge that would capture the halt word
        do_reset();
        run_plain(7);
        set_in(1'b0, 1'b0, 1'b1, 16'h0002);
        tick();
        checks++;
        if (act !== exp_vec() || {halted, imem_addr, if_valid} !== {1'b0, 16'h0002, 1'b0}) begin
            failures++; $display("FAIL halt_vs_redirect act=%h exp=%h", act, exp_vec());
        end
        set_in(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checks++;
        if (act !== exp_vec() || if_instr !== 16'h0280) begin
            failures++; $display("FAIL after_redirect act=%h exp=%h", act, exp_vec());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 16'hFFFF);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checks++;
        if (act !== exp_vec() ||
            {if_instr, if_pc, if_pc_plus1, imem_addr} !== {16'h0000, 16'hFFFF, 16'h0000, 16'h0000}) begin
            failures++; $display("FAIL wrap act=%h exp=%h", act, exp_vec());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        run_plain(4);
        set_in(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (act !== exp_vec()) begin
            failures++; $display("FAIL async_reset act=%h exp=%h", act, exp_vec());
        end
        @(posedge clk); #1;
        checks++;
        if (act !== exp_vec()) begin
            failures++; $display("FAIL reset_held act=%h exp=%h", act, exp_vec());
        end
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_random();
        for (int a = 0; a < 64; a++) begin
            if ($urandom_range(7, 0) == 0) rom[a] = HALT;
        end
        do_reset();
        for (int i = 0; i < 500; i++) begin
            set_in($urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0,
                   $urandom_range(9, 0) == 0, 16'($urandom_range(63, 0)));
            tick();
            checks++;
            if (act !== exp_vec()) begin
                failures++; $display("FAIL random_%0d act=%h exp=%h", i, act, exp_vec());
            end
`ifdef FETCH_PERF_CNT_EN
            checks++;
            if ({fetch_count, stall_count} !== {m_fetch, m_stallc}) begin
                failures++;
                $display("FAIL perf_%0d act=%h/%h exp=%h/%h", i, fetch_count, stall_count, m_fetch, m_stallc);
            end
`endif
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) rom[a] = 16'($urandom) & 16'h7FFF;
        for (int a = 0; a < 6; a++) rom[a] = prog[a];
        rom[6]     = HALT;
        rom[16'hFFFF] = 16'h0000;

        test_reset();
        test_sequence();
        test_stall();
        test_redirect();
        test_flush();
        test_halt();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
